// File: rtl/t4l4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : t4l4_pkg
// Brief    : Shared width constant and flag type for the t4l4 comparator.
// Revision : 1.0
// ============================================================================
package t4l4_pkg;

  localparam int T4L4_WIDTH = 4;

  typedef struct packed {
    logic gt;
    logic eq;
  } cmp_flags_t;

endpackage : t4l4_pkg
`default_nettype wire

// File: rtl/t4l4_if.sv
`default_nettype none
// ============================================================================
// Module   : t4l4_if
// Brief    : Operand and flag bundle between a driver and the t4l4 comparator.
// Revision : 1.0
// ============================================================================
interface t4l4_if
  import t4l4_pkg::*;
#(
  parameter int WIDTH = T4L4_WIDTH
) ();

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out1;
  logic             out2;

  modport master (output A, output B, input out1, input out2);
  modport slave  (input A, input B, output out1, output out2);

endinterface : t4l4_if
`default_nettype wire

// File: rtl/t4l4_cmp_slice.sv
`default_nettype none
// ============================================================================
// Module   : cmp_slice
// Brief    : One-bit magnitude-compare slice, chained from MSB towards LSB.
// Revision : 1.0
// ============================================================================
module cmp_slice
  import t4l4_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic gt_in,
  input  logic eq_in,
  output logic gt_out,
  output logic eq_out
);

  // A higher bit already decided "greater"; otherwise this bit decides if still tied.
  assign gt_out = gt_in | (eq_in & a & ~b);
  assign eq_out = eq_in & ~(a ^ b);

endmodule : cmp_slice
`default_nettype wire

// File: rtl/t4l4.sv
`default_nettype none
// ============================================================================
// Module   : t4l4
// Brief    : Registered unsigned comparator: out1 = (A > B), out2 = (A == B).
// Revision : 1.0
// ============================================================================
module t4l4
  import t4l4_pkg::*;
#(
  parameter int WIDTH = T4L4_WIDTH
) (
  input logic   clk,
  input logic   rst,
  t4l4_if.slave bus
);

  // Index WIDTH is the seed entering the MSB slice; index 0 is the LSB result.
  logic [WIDTH:0] w_gt;
  logic [WIDTH:0] w_eq;
  cmp_flags_t     r_flags;

  assign w_gt[WIDTH] = 1'b0;
  assign w_eq[WIDTH] = 1'b1;

  generate
    for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_slice
      cmp_slice u_slice (
        .a      (bus.A[i]),
        .b      (bus.B[i]),
        .gt_in  (w_gt[i+1]),
        .eq_in  (w_eq[i+1]),
        .gt_out (w_gt[i]),
        .eq_out (w_eq[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= '0;
    end else begin
      r_flags.gt <= w_gt[0];
      r_flags.eq <= w_eq[0];
    end
  end

  assign bus.out1 = r_flags.gt;
  assign bus.out2 = r_flags.eq;

endmodule : t4l4
`default_nettype wire

// File: tb/tb_t4l4.sv
`default_nettype none
// ============================================================================
// Module   : tb_t4l4
// Brief    : Directed and exhaustive self-checking bench for t4l4.
// Revision : 1.0
// ============================================================================
module tb_t4l4;
  import t4l4_pkg::*;

  localparam int W = T4L4_WIDTH;

  logic clk;
  logic rst;

  t4l4_if #(.WIDTH(W)) bus ();

  t4l4 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
    n_tests++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed {out1,out2}=%b expected %b", tag, obs, exp_v);
    end
  endtask

  // Drive operands and queue the result the output register must show after the next edge.
  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [1:0] e;
    bus.A = a;
    bus.B = b;
    e[1] = (int'(a) > int'(b));
    e[0] = (int'(a) == int'(b));
    exp_q.push_back(e);
  endtask

  task automatic step(input string tag);
    logic [1:0] obs;
    @(posedge clk);
    #1;
    obs = {bus.out1, bus.out2};
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, obs, 2'bxx);
    end else begin
      check(tag, obs, exp_q.pop_front());
    end
    n_tests++;
    assert (!(bus.out1 && bus.out2))
    else begin
      n_fail++;
      $error("FAIL %s_exclusive: observed out1=%b out2=%b expected not both 1", tag, bus.out1, bus.out2);
    end
  endtask

  initial begin
    rst   = 1'b1;
    bus.A = '0;
    bus.B = '0;
    #2;
    check("reset_no_edge", {bus.out1, bus.out2}, 2'b00);

    @(negedge clk);
    rst = 1'b0;
    apply(4'b0000, 4'b0000);
    step("zero_eq");

    apply(4'b1011, 4'b0001);
    #3;
    check("hold_before_edge", {bus.out1, bus.out2}, 2'b01);
    step("a_gt_b");

    apply(4'b1100, 4'b1101);
    step("a_lt_b");

    // Operands wiggle between edges; only the value present at the edge counts.
    bus.A = 4'b0000;
    bus.B = 4'b1111;
    #2;
    bus.A = 4'b0111;
    #1;
    check("glitch_hold", {bus.out1, bus.out2}, 2'b00);
    apply(4'b1111, 4'b0000);
    step("max_vs_zero");

    apply(4'b0000, 4'b1111);
    step("zero_vs_max");

    apply(4'b1111, 4'b1111);
    step("max_eq");

    #2;
    rst = 1'b1;
    #1;
    check("async_clear", {bus.out1, bus.out2}, 2'b00);
    rst = 1'b0;
    #1;
    check("clear_hold", {bus.out1, bus.out2}, 2'b00);
    apply(4'b1111, 4'b1111);
    step("after_reset_eq");

    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        apply(W'(a), W'(b));
        step("sweep");
      end
    end

    n_tests++;
    assert (exp_q.size() == 0)
    else begin
      n_fail++;
      $error("FAIL queue_drain: observed %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_t4l4
`default_nettype wire

// File: doc/t4l4.md
T4L4 -- requirements
Module: t4l4

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; the block SHALL be verified at WIDTH=4.
REQ-002 clk  input  1  rising-edge clock, the only clock in the block.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 A  input  WIDTH  unsigned operand A.
REQ-005 B  input  WIDTH  unsigned operand B.
REQ-006 out1  output  1  registered flag, high when A > B (unsigned).
REQ-007 out2  output  1  registered flag, high when A == B.

Function
REQ-008 The block SHALL compare A and B as unsigned integers; there is no signed mode.
REQ-009 On each rising clk edge with rst low, out1 SHALL load (A > B) and out2 SHALL load (A == B), both sampled at that edge.
REQ-010 Latency SHALL be exactly one clock: the flags reflect the operands present at the previous rising edge.
REQ-011 A < B SHALL be signalled by out1=0 and out2=0; out1 and out2 SHALL never both be 1.
REQ-012 Boundaries: A=B=0 gives out1=0, out2=1; A=all-ones, B=0 gives out1=1, out2=0; A=0, B=all-ones gives 0,0; A=B=all-ones gives 0,1.
REQ-013 The comparison SHALL be purely combinational from the registered inputs' point of view: no pipelining beyond the single output register, and no input registering.
REQ-014 Operands that change between edges SHALL have no effect on outputs until the next rising edge (no glitches visible on out1/out2).

Reset
REQ-015 While rst is high, out1 and out2 SHALL be 0 immediately, independent of clk.
REQ-016 Asserting rst mid-operation SHALL clear both flags asynchronously; the first edge after rst falls SHALL load the compare result of the then-current A and B.
REQ-017 No other state exists; reset SHALL leave nothing else to initialise.

Structure
REQ-018 A shared package SHALL hold the default width constant (4) used by t4l4 and its bench.
REQ-019 The comparator SHALL be built from a one-bit slice sub-module named cmp_slice (inputs a, b, gt_in, eq_in; outputs gt_out, eq_out), cascaded MSB to LSB, WIDTH instances via generate.
REQ-020 The MSB slice SHALL receive gt_in=0, eq_in=1; the LSB slice outputs feed the out1/out2 registers.
REQ-021 cmp_slice rule: gt_out = gt_in OR (eq_in AND a AND NOT b); eq_out = eq_in AND (a XNOR b).

Verification
REQ-022 rst high, A=0000, B=0000 -> out1=0, out2=0 with no clock edge required.
REQ-023 rst low, A=0000, B=0000, one edge -> out1=0, out2=1.
REQ-024 A=1011, B=0001, one edge -> out1=1, out2=0; outputs unchanged before that edge.
REQ-025 A=1100, B=1101, one edge -> out1=0, out2=0.
REQ-026 A=1111, B=1111, one edge -> out1=0, out2=1; then assert rst between edges -> both 0 at once; deassert, one edge -> out2=1 again.
REQ-027 Exhaustive sweep of all 256 (A,B) pairs with a one-cycle-delayed model check -> zero mismatches, and out1 AND out2 never 1.
